// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the fetch PC, issues credit-limited requests, buffers returns.
// Optional FETCH_PERF_CNT_EN adds pop and stall performance counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [31:0]   pc_r;
    logic          inflight_r;
    logic [31:0]   inflight_pc_r;
    logic [31:0]   data_mem_r [FIFO_DEPTH];
    logic [31:0]   pc_mem_r   [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;

    logic [CW-1:0] credit_s;
    logic          issue_s;
    logic          push_s;
    logic          valid_s;
    logic          pop_s;

    // Credits come only from registered occupancy, so a pop frees a slot one cycle later.
    assign credit_s = count_r + CW'(inflight_r);
    assign issue_s  = rst & ~redirect & (credit_s < DEPTH_C);
    // The response landing in a redirect cycle belongs to the old stream and is dropped.
    assign push_s   = inflight_r & ~redirect;
    assign valid_s  = (count_r != {CW{1'b0}}) & ~redirect;
    assign pop_s    = valid_s & inst_ready;

    assign imem_req   = issue_s;
    assign imem_addr  = pc_r;
    assign inst_valid = valid_s;
    assign inst       = data_mem_r[rd_ptr_r];
    assign inst_pc    = pc_mem_r[rd_ptr_r];

    // Fetch PC and single outstanding-request tracker.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_r          <= RESET_PC;
            inflight_r    <= 1'b0;
            inflight_pc_r <= 32'h0000_0000;
        end else if (redirect) begin
            pc_r       <= redirect_pc & 32'hFFFF_FFFC;
            inflight_r <= 1'b0;
        end else if (issue_s) begin
            pc_r          <= pc_r + 32'd4;
            inflight_r    <= 1'b1;
            inflight_pc_r <= pc_r;
        end else begin
            inflight_r <= 1'b0;
        end
    end

    // Buffer pointers and occupancy; a redirect empties the buffer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (redirect) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            count_r <= count_r + CW'(push_s) - CW'(pop_s);
        end
    end

    // Buffer storage; cleared on reset so the head reads zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                data_mem_r[i] <= 32'h0000_0000;
                pc_mem_r[i]   <= 32'h0000_0000;
            end
        end else if (push_s) begin
            data_mem_r[wr_ptr_r] <= imem_rdata;
            pc_mem_r[wr_ptr_r]   <= inflight_pc_r;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_r;
    logic [31:0] perf_stall_r;

    // Performance counters survive redirects; only reset clears them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetch_r <= 32'h0000_0000;
            perf_stall_r <= 32'h0000_0000;
        end else begin
            perf_fetch_r <= perf_fetch_r + 32'(pop_s);
            perf_stall_r <= perf_stall_r + 32'(valid_s & ~inst_ready);
        end
    end

    assign perf_fetch_cnt = perf_fetch_r;
    assign perf_stall_cnt = perf_stall_r;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: requested PCs are queued and matched against accepted instructions.
// A second instance runs with RESET_PC near the top of the address space to exercise PC wrap.
module tb_fetch_stage;

    localparam logic [31:0] K = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        inst_valid;
    logic        inst_ready = 1'b1;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    logic        w_req;
    logic [31:0] w_addr;
    logic [31:0] w_rdata;
    logic        w_redirect = 1'b0;
    logic [31:0] w_redirect_pc = 32'h0;
    logic        w_valid;
    logic        w_ready = 1'b1;
    logic [31:0] w_inst;
    logic [31:0] w_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt, perf_stall_cnt, w_perf_fetch, w_perf_stall;
`endif

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_addr;

    always #5 clk = ~clk;

    fetch_stage u_dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc)
`ifdef FETCH_PERF_CNT_EN
        , .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) u_wrap (
        .clk(clk), .rst(rst), .imem_req(w_req), .imem_addr(w_addr),
        .imem_rdata(w_rdata), .redirect(w_redirect), .redirect_pc(w_redirect_pc),
        .inst_valid(w_valid), .inst_ready(w_ready), .inst(w_inst), .inst_pc(w_pc)
`ifdef FETCH_PERF_CNT_EN
        , .perf_fetch_cnt(w_perf_fetch), .perf_stall_cnt(w_perf_stall)
`endif
    );

    // Synchronous instruction memories: data is a function of the address.
    always @(posedge clk) begin
        if (imem_req === 1'b1) imem_rdata <= imem_addr ^ K;
        if (w_req === 1'b1) w_rdata <= w_addr ^ K;
    end

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0; redirect = 1'b0; inst_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        exp_addr = 32'h0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        total++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h0 || inst_valid !== 1'b0) begin
            bad++; $display("FAIL reset_ctl: req=%b addr=%h valid=%b, want 0 00000000 0", imem_req, imem_addr, inst_valid);
        end
        total++;
        if (inst !== 32'h0 || inst_pc !== 32'h0) begin
            bad++; $display("FAIL reset_data: inst=%h pc=%h, want 0 0", inst, inst_pc);
        end
        total++;
        if (w_addr !== 32'hFFFF_FFF8 || w_req !== 1'b0) begin
            bad++; $display("FAIL reset_pc_param: addr=%h req=%b, want fffffff8 0", w_addr, w_req);
        end
    endtask

    task automatic test_stream();
        int pops;
        logic [31:0] e;
        pops = 0;
        apply_reset();
        for (int c = 0; c < 14; c++) begin
            if (c != 0) @(negedge clk);
            inst_ready = 1'b1; redirect = 1'b0;
            #1;
            if (c == 0) begin
                total++;
                if (imem_req !== 1'b1) begin bad++; $display("FAIL first_req: req=%b, want 1", imem_req); end
            end
            if (c == 1) begin
                total++;
                if (inst_valid !== 1'b0) begin bad++; $display("FAIL early_valid: valid=%b, want 0", inst_valid); end
            end
            if (c == 2) begin
                total++;
                if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin
                    bad++; $display("FAIL first_valid: valid=%b pc=%h, want 1 00000000", inst_valid, inst_pc);
                end
            end
            if (imem_req === 1'b1) begin
                total++;
                if (imem_addr !== exp_addr) begin bad++; $display("FAIL stream_addr: got %h want %h", imem_addr, exp_addr); end
                exp_q.push_back(exp_addr); exp_addr = exp_addr + 32'd4;
            end
            if (inst_valid === 1'b1 && inst_ready === 1'b1) begin
                total++; pops++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL stream_extra: pc=%h, want none", inst_pc); end
                else begin
                    e = exp_q.pop_front();
                    if (inst_pc !== e || inst !== (e ^ K)) begin
                        bad++; $display("FAIL stream_inst: pc=%h inst=%h, want %h %h", inst_pc, inst, e, e ^ K);
                    end
                end
            end
        end
        total++;
        if (pops < 6) begin bad++; $display("FAIL stream_count: pops=%0d, want >=6", pops); end
    endtask

    task automatic test_backpressure();
        int pops;
        logic [31:0] e;
        pops = 0;
        apply_reset();
        for (int c = 0; c < 17; c++) begin
            if (c != 0) @(negedge clk);
            inst_ready = (c >= 2 && c <= 6) ? 1'b0 : 1'b1;
            #1;
            if (c >= 2 && c <= 6) begin
                total++;
                if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst !== K || imem_req !== 1'b0) begin
                    bad++; $display("FAIL stall_hold: valid=%b pc=%h inst=%h req=%b, want 1 00000000 %h 0", inst_valid, inst_pc, inst, imem_req, K);
                end
                total++;
                if (exp_q.size() != 2) begin bad++; $display("FAIL stall_depth: outstanding=%0d, want 2", exp_q.size()); end
            end
            if (imem_req === 1'b1) begin
                total++;
                if (imem_addr !== exp_addr) begin bad++; $display("FAIL bp_addr: got %h want %h", imem_addr, exp_addr); end
                exp_q.push_back(exp_addr); exp_addr = exp_addr + 32'd4;
            end
            if (inst_valid === 1'b1 && inst_ready === 1'b1) begin
                total++; pops++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL bp_extra: pc=%h, want none", inst_pc); end
                else begin
                    e = exp_q.pop_front();
                    if (inst_pc !== e || inst !== (e ^ K)) begin
                        bad++; $display("FAIL bp_inst: pc=%h inst=%h, want %h %h", inst_pc, inst, e, e ^ K);
                    end
                end
            end
        end
        total++;
        if (pops < 3) begin bad++; $display("FAIL bp_count: pops=%0d, want >=3", pops); end
`ifdef FETCH_PERF_CNT_EN
        @(negedge clk);
        inst_ready = 1'b0;
        #1;
        total++;
        if (perf_fetch_cnt !== 32'(pops) || perf_stall_cnt !== 32'd5) begin
            bad++; $display("FAIL perf_counts: fetch=%0d stall=%0d, want %0d 5", perf_fetch_cnt, perf_stall_cnt, pops);
        end
`endif
    endtask

    task automatic test_redirect();
        logic [31:0] e;
        apply_reset();
        for (int c = 0; c < 22; c++) begin
            if (c != 0) @(negedge clk);
            inst_ready = (c < 5) ? 1'b0 : 1'b1;
            redirect = (c == 5 || c == 12 || c == 13) ? 1'b1 : 1'b0;
            redirect_pc = (c == 5) ? 32'h0000_0103 : (c == 12) ? 32'h0000_0200 : 32'h0000_0300;
            #1;
            if (c == 6) begin
                total++;
                if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
                    bad++; $display("FAIL redir_addr: req=%b addr=%h, want 1 00000100", imem_req, imem_addr);
                end
            end
            if (c == 6 || c == 7 || c == 14 || c == 15) begin
                total++;
                if (inst_valid !== 1'b0) begin bad++; $display("FAIL redir_stale: cycle %0d valid=%b pc=%h, want 0", c, inst_valid, inst_pc); end
            end
            if (c == 8 || c == 16) begin
                total++;
                e = (c == 8) ? 32'h100 : 32'h300;
                if (inst_valid !== 1'b1 || inst_pc !== e) begin
                    bad++; $display("FAIL redir_first: valid=%b pc=%h, want 1 %h", inst_valid, inst_pc, e);
                end
            end
            if (redirect) begin
                total++;
                if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin
                    bad++; $display("FAIL redir_quiet: req=%b valid=%b, want 0 0", imem_req, inst_valid);
                end
                exp_q.delete(); exp_addr = redirect_pc & 32'hFFFF_FFFC;
            end else begin
                if (imem_req === 1'b1) begin
                    total++;
                    if (imem_addr !== exp_addr) begin bad++; $display("FAIL redir_seq_addr: got %h want %h", imem_addr, exp_addr); end
                    exp_q.push_back(exp_addr); exp_addr = exp_addr + 32'd4;
                end
                if (inst_valid === 1'b1 && inst_ready === 1'b1) begin
                    total++;
                    if (exp_q.size() == 0) begin bad++; $display("FAIL redir_extra: pc=%h, want none", inst_pc); end
                    else begin
                        e = exp_q.pop_front();
                        if (inst_pc !== e || inst !== (e ^ K)) begin
                            bad++; $display("FAIL redir_inst: pc=%h inst=%h, want %h %h", inst_pc, inst, e, e ^ K);
                        end
                    end
                end
            end
        end
        redirect = 1'b0;
    endtask

    task automatic test_wrap();
        logic [31:0] wq[$];
        logic [31:0] waddr;
        logic [31:0] e;
        int pops;
        pops = 0;
        waddr = 32'hFFFF_FFF8;
        apply_reset();
        for (int c = 0; c < 10; c++) begin
            if (c != 0) @(negedge clk);
            #1;
            if (w_req === 1'b1) begin
                total++;
                if (w_addr !== waddr) begin bad++; $display("FAIL wrap_addr: got %h want %h", w_addr, waddr); end
                wq.push_back(waddr); waddr = waddr + 32'd4;
            end
            if (w_valid === 1'b1) begin
                total++; pops++;
                if (wq.size() == 0) begin bad++; $display("FAIL wrap_extra: pc=%h, want none", w_pc); end
                else begin
                    e = wq.pop_front();
                    if (w_pc !== e || w_inst !== (e ^ K)) begin
                        bad++; $display("FAIL wrap_inst: pc=%h inst=%h, want %h %h", w_pc, w_inst, e, e ^ K);
                    end
                end
            end
        end
        total++;
        if (pops < 4) begin bad++; $display("FAIL wrap_count: pops=%0d, want >=4", pops); end
`ifdef FETCH_PERF_CNT_EN
        total++;
        if (w_perf_fetch !== 32'(pops - 1)) begin bad++; $display("FAIL wrap_perf: fetch=%0d, want %0d", w_perf_fetch, pops - 1); end
`endif
    endtask

    task automatic test_reset_mid();
        logic [31:0] e;
        int pops;
        pops = 0;
        apply_reset();
        inst_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c != 0) @(negedge clk);
            #1;
        end
        total++;
        if (inst_valid !== 1'b1) begin bad++; $display("FAIL mid_pre_valid: valid=%b, want 1", inst_valid); end
        #2;
        rst = 1'b0;
        #1;
        total++;
        if (inst_valid !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 32'h0 || inst_pc !== 32'h0) begin
            bad++; $display("FAIL mid_async: valid=%b req=%b addr=%h pc=%h, want 0 0 0 0", inst_valid, imem_req, imem_addr, inst_pc);
        end
`ifdef FETCH_PERF_CNT_EN
        total++;
        if (perf_fetch_cnt !== 32'h0 || perf_stall_cnt !== 32'h0) begin
            bad++; $display("FAIL mid_perf: fetch=%0d stall=%0d, want 0 0", perf_fetch_cnt, perf_stall_cnt);
        end
`endif
        @(negedge clk);
        rst = 1'b1; inst_ready = 1'b1;
        exp_q.delete(); exp_addr = 32'h0;
        for (int c = 0; c < 8; c++) begin
            if (c != 0) @(negedge clk);
            #1;
            if (imem_req === 1'b1) begin
                total++;
                if (imem_addr !== exp_addr) begin bad++; $display("FAIL mid_addr: got %h want %h", imem_addr, exp_addr); end
                exp_q.push_back(exp_addr); exp_addr = exp_addr + 32'd4;
            end
            if (inst_valid === 1'b1 && inst_ready === 1'b1) begin
                total++; pops++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL mid_extra: pc=%h, want none", inst_pc); end
                else begin
                    e = exp_q.pop_front();
                    if (inst_pc !== e || inst !== (e ^ K)) begin
                        bad++; $display("FAIL mid_inst: pc=%h inst=%h, want %h %h", inst_pc, inst, e, e ^ K);
                    end
                end
            end
        end
        total++;
        if (pops < 3) begin bad++; $display("FAIL mid_count: pops=%0d, want >=3", pops); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
